// File: rtl/if_prefetch_stage_if.sv
// Instruction-fetch bus bundle: memory request/response channel toward the
// instruction memory and the valid/ready channel toward decode.
interface if_prefetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] PC_IF;
  logic [31:0]     INSTRUCTION_IF;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid, PC_IF, INSTRUCTION_IF,
    input  id_ready
  );

  // Memory / decode environment side
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid, PC_IF, INSTRUCTION_IF,
    output id_ready
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Prefetching instruction-fetch stage. Issues in-order requests to a
// variable-latency instruction memory, buffers {PC, instruction} pairs in a
// small FIFO and hands them to decode. Redirects flush the FIFO and drop the
// responses of requests already in flight.
// Optional macro IF_MISALIGN_CHECK_EN adds fetch_misaligned and stalls fetch
// after a redirect to a non-word-aligned target.
module if_prefetch_stage #(
  parameter int unsigned XLEN            = 32,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PCSrc,
  input  logic [XLEN-1:0]      PC_Branch,
`ifdef IF_MISALIGN_CHECK_EN
  output logic                 fetch_misaligned,
`endif
  if_prefetch_stage_if.master  bus
);

  localparam int unsigned CNT_MAX = (FIFO_DEPTH > MAX_OUTSTANDING) ? FIFO_DEPTH : MAX_OUTSTANDING;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned SW      = CW + 1;
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  entry_t          head_q, head_d;
  entry_t          push_entry_c;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next_c;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   cnt_after_pop_c;
  logic [SW-1:0]   inflight_c;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [XLEN-1:0] target_c;
  logic            req_c, grant_c, push_c, pop_c, fetch_stall_c;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign fetch_stall_c    = misalign_q;
  assign fetch_misaligned = misalign_q;
`else
  logic unused_pc_branch_lsb;
  assign fetch_stall_c        = 1'b0;
  assign unused_pc_branch_lsb = ^PC_Branch[1:0];
`endif

  // Handshake qualifiers; issue is conservative and counts slots already promised
  always_comb begin
    target_c        = {PC_Branch[XLEN-1:2], 2'b00};
    inflight_c      = SW'(fifo_cnt_q) + SW'(out_cnt_q) - SW'(drop_cnt_q);
    req_c           = reset && !PCSrc && !fetch_stall_c &&
                      (out_cnt_q < CW'(MAX_OUTSTANDING)) &&
                      (inflight_c < SW'(FIFO_DEPTH));
    grant_c         = req_c && bus.imem_gnt;
    push_c          = bus.imem_rvalid && (drop_cnt_q == '0) && !PCSrc;
    pop_c           = (fifo_cnt_q != '0) && bus.id_ready && !PCSrc;
    push_entry_c    = '{pc: resp_pc_q, instr: bus.imem_rdata};
    rd_next_c       = rd_ptr_q + PW'(1);
    cnt_after_pop_c = fifo_cnt_q - CW'(pop_c);
  end

  // Next-state for pointers, counters, PCs and the registered head entry
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    head_d     = head_q;
`ifdef IF_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    if (PCSrc) begin
      fetch_pc_d = target_c;
      resp_pc_d  = target_c;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fifo_cnt_d = '0;
      out_cnt_d  = out_cnt_q - CW'(bus.imem_rvalid);
      drop_cnt_d = out_cnt_q - CW'(bus.imem_rvalid);
`ifdef IF_MISALIGN_CHECK_EN
      misalign_d = (PC_Branch[1:0] != 2'b00);
`endif
    end else begin
      if (grant_c) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push_c) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_d = rd_next_c;
      fifo_cnt_d = fifo_cnt_q + CW'(push_c) - CW'(pop_c);
      out_cnt_d  = out_cnt_q + CW'(grant_c) - CW'(bus.imem_rvalid);
      if (bus.imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      // Head follows the oldest entry; it holds when the FIFO drains empty
      if (push_c && (cnt_after_pop_c == '0)) head_d = push_entry_c;
      else if (pop_c && (cnt_after_pop_c != '0)) head_d = mem_q[rd_next_c];
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= XLEN'(RESET_PC);
      resp_pc_q  <= XLEN'(RESET_PC);
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      head_q     <= '{pc: XLEN'(RESET_PC), instr: NOP};
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      head_q     <= head_d;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= push_entry_c;
  end

  assign bus.imem_req       = req_c;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.id_valid       = (fifo_cnt_q != '0);
  assign bus.PC_IF          = head_q.pc;
  assign bus.INSTRUCTION_IF = head_q.instr;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with an in-order memory model of
// configurable response latency.
module tb_if_prefetch_stage;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            pcsrc;
  logic [XLEN-1:0] pc_branch;
`ifdef IF_MISALIGN_CHECK_EN
  logic            mis;
`endif

  if_prefetch_stage_if #(.XLEN(XLEN)) bus ();

  if_prefetch_stage #(
    .XLEN(XLEN), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PCSrc(pcsrc),
    .PC_Branch(pc_branch),
`ifdef IF_MISALIGN_CHECK_EN
    .fetch_misaligned(mis),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Sampled DUT state for the current cycle (taken at the falling edge)
  logic        s_req, s_gnt, s_valid, s_rvalid, s_rst, s_mis;
  logic [31:0] s_addr, s_pc, s_instr;

  // Memory model: granted addresses with their issue cycle
  logic [31:0] pend_a[$];
  int          pend_c[$];
  int          cyc = 0;
  int          lat = 1;

  logic        got_g, got_v;
  logic [31:0] first_g, first_pc, first_in;
  int          grants;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then after the edge update the memory model
  task automatic cycle();
    @(negedge clk);
    s_req    = bus.imem_req;
    s_gnt    = bus.imem_gnt;
    s_addr   = bus.imem_addr;
    s_valid  = bus.id_valid;
    s_pc     = bus.PC_IF;
    s_instr  = bus.INSTRUCTION_IF;
    s_rvalid = bus.imem_rvalid;
    s_rst    = reset;
`ifdef IF_MISALIGN_CHECK_EN
    s_mis    = mis;
`else
    s_mis    = 1'b0;
`endif
    @(posedge clk);
    #1;
    cyc++;
    if (!s_rst) begin
      pend_a.delete();
      pend_c.delete();
    end else if (s_req && s_gnt) begin
      pend_a.push_back(s_addr);
      pend_c.push_back(cyc - 1);
    end
    if (s_rst && (pend_a.size() > 0) && (cyc - pend_c[0] >= lat)) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = instr_of(pend_a.pop_front());
      void'(pend_c.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pcsrc = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  // Run until id_valid shows up (bounded), tracking the first grant address
  task automatic wait_valid(input int budget);
    got_g = 1'b0;
    got_v = 1'b0;
    for (int i = 0; i < budget && !got_v; i++) begin
      cycle();
      if (!got_g && s_req && s_gnt) begin got_g = 1'b1; first_g = s_addr; end
      if (s_valid) begin got_v = 1'b1; first_pc = s_pc; first_in = s_instr; end
    end
  endtask

  initial begin
    reset           = 1'b0;
    pcsrc           = 1'b0;
    pc_branch       = '0;
    bus.id_ready    = 1'b1;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;

    // Reset state and zero-wait streaming
    do_reset();
    check_eq("rst_valid", s_valid, 0);
    check_eq("rst_req", s_req, 0);
    check_eq("rst_pc", s_pc, 32'h0);
    check_eq("rst_instr", s_instr, 32'h0000_0013);
    cycle();
    check_eq("t1_req0", s_req, 1);
    check_eq("t1_addr0", s_addr, 32'h0);
    cycle();
    check_eq("t1_addr1", s_addr, 32'h4);
    check_eq("t1_valid_early", s_valid, 0);
    cycle();
    check_eq("t1_valid_first", s_valid, 1);
    check_eq("t1_pc_first", s_pc, 32'h0);
    check_eq("t1_instr_first", s_instr, instr_of(32'h0));
    check_eq("t1_addr2", s_addr, 32'h8);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check_eq("t1_stream_valid", s_valid, 1);
      check_eq("t1_stream_pc", s_pc, 32'(4 * k));
      check_eq("t1_stream_instr", s_instr, instr_of(32'(4 * k)));
    end

    // Backpressure fills the FIFO, then drains in order
    do_reset();
    bus.id_ready = 1'b0;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_req && s_gnt) grants++;
    end
    check_eq("t2_grants", 32'(grants), 4);
    check_eq("t2_req_low", s_req, 0);
    check_eq("t2_head_valid", s_valid, 1);
    check_eq("t2_head_pc", s_pc, 32'h0);
    bus.id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("t2_drain_valid", s_valid, 1);
      check_eq("t2_drain_pc", s_pc, 32'(4 * k));
    end

    // Redirect with two requests outstanding
    do_reset();
    lat = 1000;
    pcsrc = 1'b1; pc_branch = 32'h10;
    cycle();
    pcsrc = 1'b0;
    cycle();
    check_eq("t3_grant_10", (s_req && s_gnt) ? s_addr : 32'hDEAD_BEEF, 32'h10);
    cycle();
    check_eq("t3_grant_14", (s_req && s_gnt) ? s_addr : 32'hDEAD_BEEF, 32'h14);
    pcsrc = 1'b1; pc_branch = 32'h200; lat = 1;
    cycle();
    check_eq("t3_redirect_req", s_req, 0);
    pcsrc = 1'b0;
    wait_valid(20);
    check_eq("t3_seen_grant", got_g, 1);
    check_eq("t3_first_grant", first_g, 32'h200);
    check_eq("t3_seen_valid", got_v, 1);
    check_eq("t3_first_pc", first_pc, 32'h200);
    check_eq("t3_first_instr", first_in, instr_of(32'h200));

    // Redirect coinciding with rvalid and a pop on a non-empty FIFO
    do_reset();
    lat = 2;
    bus.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    pcsrc = 1'b1; pc_branch = 32'h80; bus.id_ready = 1'b1;
    cycle();
    check_eq("t4_pre_valid", s_valid, 1);
    check_eq("t4_pre_rvalid", s_rvalid, 1);
    check_eq("t4_pre_pc", s_pc, 32'h0);
    pcsrc = 1'b0;
    cycle();
    check_eq("t4_valid_after", s_valid, 0);
    check_eq("t4_grant_target", (s_req && s_gnt) ? s_addr : 32'hDEAD_BEEF, 32'h80);
    wait_valid(20);
    check_eq("t4_seen_valid", got_v, 1);
    check_eq("t4_first_pc", first_pc, 32'h80);
    check_eq("t4_first_instr", first_in, instr_of(32'h80));

    // PC wrap at the top of the address space
    do_reset();
    lat = 1;
    pcsrc = 1'b1; pc_branch = 32'hFFFF_FFFC;
    cycle();
    pcsrc = 1'b0;
    cycle();
    check_eq("t5_addr_top", s_addr, 32'hFFFF_FFFC);
    cycle();
    check_eq("t5_addr_wrap", s_addr, 32'h0);
    cycle();
    check_eq("t5_pc_top", s_pc, 32'hFFFF_FFFC);
    cycle();
    check_eq("t5_pc_wrap", s_pc, 32'h0);

    // Reset while two requests are outstanding
    pcsrc = 1'b1; pc_branch = 32'h40; lat = 2; bus.id_ready = 1'b0;
    cycle();
    pcsrc = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    reset = 1'b0;
    cycle();
    check_eq("t6_pre_valid", s_valid, 1);
    check_eq("t6_pre_pc", s_pc, 32'h40);
    reset = 1'b1;
    cycle();
    check_eq("t6_valid", s_valid, 0);
    check_eq("t6_addr", s_addr, 32'h0);
    check_eq("t6_req", s_req, 1);
    check_eq("t6_pc", s_pc, 32'h0);
    check_eq("t6_instr", s_instr, 32'h0000_0013);

    // Misaligned redirect target
    do_reset();
    lat = 1;
    bus.id_ready = 1'b1;
    pcsrc = 1'b1; pc_branch = 32'h102;
    cycle();
    pcsrc = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) cycle();
    check_eq("t7_mis_set", s_mis, 1);
    check_eq("t7_req_held", s_req, 0);
    pcsrc = 1'b1; pc_branch = 32'h300;
    cycle();
    pcsrc = 1'b0;
    cycle();
    check_eq("t7_mis_clr", s_mis, 0);
    check_eq("t7_req", s_req, 1);
    check_eq("t7_addr", s_addr, 32'h300);
`else
    cycle();
    check_eq("t7_req", s_req, 1);
    check_eq("t7_addr_aligned", s_addr, 32'h100);
    check_eq("t7_mis_absent", s_mis, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Parametrised instruction-fetch stage; successor to the single-cycle fetch block.
- Decouples the program counter from a variable-latency instruction memory using an in-order request/response interface.
- Buffers fetched {PC, instruction} pairs in a prefetch FIFO and presents them to ID with a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
- XLEN, 32, address and PC width.
- RESET_PC, 32'h0000_0000, fetch address after reset; truncated to XLEN.
- FIFO_DEPTH, 4, prefetch entries; must be a power of 2 and at least 2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests; at least 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- PCSrc  input  1  branch redirect request from EX.
- PC_Branch  input  XLEN  redirect target.
- id_ready  input  1  ID accepts the head entry.
- id_valid  output  1  head entry valid.
- PC_IF  output  XLEN  PC of the head entry.
- INSTRUCTION_IF  output  32  instruction of the head entry.
- imem_req  output  1  memory request.
- imem_addr  output  XLEN  request address, word aligned.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses return in request order.
- imem_rdata  input  32  response data.

Behaviour:
- Reset (reset==0 at a clock edge):
  - fetch_pc and resp_pc load RESET_PC.
  - FIFO is emptied; out_cnt and drop_cnt are cleared.
  - id_valid=0, imem_req=0, PC_IF=RESET_PC, INSTRUCTION_IF=32'h0000_0013 (NOP).
  - Reset takes priority over every other event, including mid-transaction; responses arriving after reset for pre-reset requests are not dropped. The memory side is reset together with this block.
- Request issue:
  - imem_req = !PCSrc && out_cnt<MAX_OUTSTANDING && (fifo_count + out_cnt − drop_cnt) < FIFO_DEPTH.
  - imem_addr = fetch_pc.
  - On imem_req && imem_gnt: fetch_pc += 4 (modulo 2^XLEN, wraps from all-ones to 0) and out_cnt increments.
- Response:
  - Every imem_rvalid decrements out_cnt.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {resp_pc, imem_rdata} is written to the FIFO tail and resp_pc += 4.
  - The issue rule guarantees the FIFO never overflows; an rvalid with out_cnt==0 is a protocol error (bench assertion).
- Output:
  - id_valid = FIFO not empty; PC_IF and INSTRUCTION_IF are driven from the FIFO head (registered storage).
  - Pop on id_valid && id_ready.
  - Latency: response on cycle N -> id_valid on cycle N+1 if the FIFO was empty.
  - When the FIFO is empty, outputs hold their last value and id_valid=0.
- Simultaneous push and pop: both are allowed in the same cycle, including with the FIFO full (the pop frees a slot; issue remains conservative and uses the pre-pop count).
- Redirect (PCSrc==1 at an edge):
  - FIFO is flushed and any pop or push that cycle is cancelled.
  - fetch_pc and resp_pc load {PC_Branch[XLEN-1:2],2'b00}.
  - drop_cnt loads out_cnt − imem_rvalid; a response in the redirect cycle is itself discarded.
  - imem_req is forced low, so no grant can occur in the redirect cycle.
  - id_valid=0 in the following cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Backpressure: with id_ready=0 the FIFO fills, issue stops once fifo_count+out_cnt−drop_cnt reaches FIFO_DEPTH, and the head holds stable.
- Invariant: all counters are sized clog2(MAX(FIFO_DEPTH, MAX_OUTSTANDING)+1) bits, and drop_cnt ≤ out_cnt always holds.

Optional Feature:
- Macro: IF_MISALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with PC_Branch[1:0]!=0 sets fetch_misaligned, flushes as usual, and suppresses imem_req until the next redirect with an aligned target, which clears the flag.
  - fetch_pc still loads the aligned-down target.
- Undefined: the port is absent and PC_Branch[1:0] are silently ignored (forced to zero).

Test Plan:
- Reset then release, zero-wait memory (gnt=1, rvalid the next cycle), id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8…; first id_valid with PC_IF=0x0 two cycles after grant; one instruction per cycle sustained thereafter.
- id_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 grants, imem_req low afterwards, head PC_IF=0x0 stable; on id_ready=1 the entries drain 0x0, 0x4, 0x8, 0xC in order.
- Two requests outstanding (0x10, 0x14), PCSrc=1 with PC_Branch=0x200 -> both responses discarded, next request address 0x200, first id_valid shows PC_IF=0x200 and none of 0x10/0x14.
- Redirect in the same cycle as rvalid and id_ready with a non-empty FIFO -> no pop is counted, the response is dropped, drop_cnt = out_cnt−1, id_valid=0 the next cycle.
- fetch_pc=0xFFFF_FFFC with XLEN=32 -> next imem_addr 0x0000_0000; reset asserted while 2 requests are outstanding -> id_valid=0 and imem_addr=RESET_PC the next cycle.
- With IF_MISALIGN_CHECK_EN, PC_Branch=0x102 -> fetch_misaligned=1 and imem_req stays 0; a following PC_Branch=0x300 -> flag cleared and a request to 0x300 is issued.
